// File: rtl/axi_vga_fb_lite_regs.sv
// axi_vga_fb_lite_regs: AXI4-Lite control-register slave for the VGA framebuffer.
// Holds four host-programmed words plus a read-only status word. The programmed
// words are copied to the video core only on frame_start, so every frame is
// rendered with one coherent configuration.
`timescale 1ns/1ps

module axi_vga_fb_lite_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  input  logic                              frame_start,
  input  logic                              vblank,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0]   active_regs
);

  localparam int         DW          = C_S_AXI_DATA_WIDTH;
  localparam int         STRB_W      = DW / 8;
  localparam int         NUM_REGS    = 4;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [2:0] IDX_STATUS  = 3'd4;

  // Program copy: what the host sees and edits.
  logic [NUM_REGS-1:0][DW-1:0] prog_q;
  logic [15:0]                 frame_cnt_q;
  logic                        pending_q;
  logic                        vblank_q;

  logic          wr_en;
  logic          rd_en;
  logic [2:0]    wr_idx;
  logic [2:0]    rd_idx;
  logic          wr_to_reg;
  logic [1:0]    wr_resp;
  logic [1:0]    rd_resp;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] status_word;
  logic          unused_addr_bits;

  // Byte-offset bits carry no information on a word-only register file.
  assign unused_addr_bits = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign wr_idx = S_AXI_AWADDR[4:2];
  assign rd_idx = S_AXI_ARADDR[4:2];

  // A write is taken only once AW and W are jointly valid and the previous
  // response has drained; reset masks the handshake so READY stays low.
  assign wr_en         = S_AXI_AWVALID & S_AXI_WVALID & ~S_AXI_BVALID & ~S_AXI_ARESET;
  assign rd_en         = S_AXI_ARVALID & ~S_AXI_RVALID & ~S_AXI_ARESET;
  assign S_AXI_AWREADY = wr_en;
  assign S_AXI_WREADY  = wr_en;
  assign S_AXI_ARREADY = rd_en;

  assign wr_to_reg = wr_en & ~wr_idx[2];
  assign wr_resp   = (wr_idx > IDX_STATUS) ? RESP_SLVERR : RESP_OKAY;

  assign status_word = {frame_cnt_q, {(DW-18){1'b0}}, vblank_q, pending_q};

  // Read address decode: program copy, status, or SLVERR with zero data.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave it unassigned and infer a latch.
    rd_data = '0;
    rd_resp = RESP_OKAY;
    if (!rd_idx[2]) begin
      rd_data = prog_q[rd_idx[1:0]];
    end else if (rd_idx == IDX_STATUS) begin
      rd_data = status_word;
    end else begin
      rd_resp = RESP_SLVERR;
    end
  end

  // Write channel: byte-lane update of the program copy and the B response.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      // NOTE: the register array is small and its reset value is visible to
      // the host, so it is cleared with the rest of the state.
      prog_q       <= '0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP  <= RESP_OKAY;
    end else if (wr_en) begin
      // NOTE: non-blocking updates mean a read or frame commit in this same
      // cycle still sees the pre-write contents.
      if (wr_to_reg) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (S_AXI_WSTRB[b]) begin
            prog_q[wr_idx[1:0]][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
          end
        end
      end
      S_AXI_BVALID <= 1'b1;
      S_AXI_BRESP  <= wr_resp;
    end else if (S_AXI_BREADY) begin
      S_AXI_BVALID <= 1'b0;
    end
  end

  // Read channel: capture data at accept and hold it until RREADY.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA  <= '0;
      S_AXI_RRESP  <= RESP_OKAY;
    end else if (rd_en) begin
      S_AXI_RVALID <= 1'b1;
      S_AXI_RDATA  <= rd_data;
      S_AXI_RRESP  <= rd_resp;
    end else if (S_AXI_RREADY) begin
      S_AXI_RVALID <= 1'b0;
    end
  end

  // Frame boundary: commit program copy, count frames, track pending edits.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      active_regs <= '0;
      frame_cnt_q <= '0;
      pending_q   <= 1'b0;
      vblank_q    <= 1'b0;
    end else begin
      vblank_q <= vblank;
      if (frame_start) begin
        active_regs <= prog_q;
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
      // A write landing on the commit edge is not in this frame, so it wins.
      if (wr_to_reg) begin
        pending_q <= 1'b1;
      end else if (frame_start) begin
        pending_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_vga_fb_lite_regs.sv
// tb_axi_vga_fb_lite_regs: directed self-checking bench for the VGA control
// register slave. Inputs change 1 ns after the rising edge; outputs are
// compared before the next rising edge.
`timescale 1ns/1ps

module tb_axi_vga_fb_lite_regs;

  logic         tb_ACLK = 1'b0;
  logic         S_AXI_ARESET;
  logic [4:0]   S_AXI_AWADDR;
  logic         S_AXI_AWVALID;
  logic         S_AXI_AWREADY;
  logic [31:0]  S_AXI_WDATA;
  logic [3:0]   S_AXI_WSTRB;
  logic         S_AXI_WVALID;
  logic         S_AXI_WREADY;
  logic [1:0]   S_AXI_BRESP;
  logic         S_AXI_BVALID;
  logic         S_AXI_BREADY;
  logic [4:0]   S_AXI_ARADDR;
  logic         S_AXI_ARVALID;
  logic         S_AXI_ARREADY;
  logic [31:0]  S_AXI_RDATA;
  logic [1:0]   S_AXI_RRESP;
  logic         S_AXI_RVALID;
  logic         S_AXI_RREADY;
  logic         frame_start;
  logic         vblank;
  logic [127:0] active_regs;

  int n_checks = 0;
  int n_errors = 0;

  always #5 tb_ACLK = ~tb_ACLK;

  axi_vga_fb_lite_regs dut (
    .S_AXI_ACLK    (tb_ACLK),
    .S_AXI_ARESET  (S_AXI_ARESET),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WSTRB   (S_AXI_WSTRB),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .S_AXI_ARADDR  (S_AXI_ARADDR),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY),
    .frame_start   (frame_start),
    .vblank        (vblank),
    .active_regs   (active_regs)
  );

  task automatic check(input string tag, input logic [127:0] observed,
                       input logic [127:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge tb_ACLK);
    #1;
  endtask

  // Full write transaction; optionally raises frame_start in the accept cycle.
  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input bit with_frame,
                           output logic [1:0] resp);
    int cyc;
    S_AXI_AWADDR  = addr;
    S_AXI_WDATA   = data;
    S_AXI_WSTRB   = strb;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WVALID  = 1'b1;
    frame_start   = with_frame;
    #1;
    cyc = 0;
    while (!S_AXI_AWREADY && cyc < 20) begin
      tick();
      cyc++;
    end
    check("wr_awready", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b11);
    tick();
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    frame_start   = 1'b0;
    check("wr_bvalid", S_AXI_BVALID, 1'b1);
    resp = S_AXI_BRESP;
    S_AXI_BREADY = 1'b1;
    tick();
    S_AXI_BREADY = 1'b0;
    check("wr_bvalid_clear", S_AXI_BVALID, 1'b0);
  endtask

  // Full read transaction returning captured data and response.
  task automatic axi_read(input logic [4:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    int cyc;
    S_AXI_ARADDR  = addr;
    S_AXI_ARVALID = 1'b1;
    #1;
    cyc = 0;
    while (!S_AXI_ARREADY && cyc < 20) begin
      tick();
      cyc++;
    end
    check("rd_arready", S_AXI_ARREADY, 1'b1);
    tick();
    S_AXI_ARVALID = 1'b0;
    check("rd_rvalid", S_AXI_RVALID, 1'b1);
    data = S_AXI_RDATA;
    resp = S_AXI_RRESP;
    S_AXI_RREADY = 1'b1;
    tick();
    S_AXI_RREADY = 1'b0;
    check("rd_rvalid_clear", S_AXI_RVALID, 1'b0);
  endtask

  task automatic frame_pulse();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // Guard against a hung handshake anywhere in the sequence.
  initial begin
    #5_000_000;
    $fatal(1, "FAIL watchdog: simulation did not reach its end");
  end

  initial begin
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic [31:0] wr_vals [4];
    wr_vals[0] = 32'h0101FFFF;
    wr_vals[1] = 32'hABCD0001;
    wr_vals[2] = 32'hDEAD0011;
    wr_vals[3] = 32'hBEEF0011;

    // Reset with requests pending: nothing may be accepted.
    S_AXI_ARESET  = 1'b1;
    S_AXI_AWADDR  = '0;
    S_AXI_WDATA   = '0;
    S_AXI_WSTRB   = '0;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WVALID  = 1'b1;
    S_AXI_BREADY  = 1'b0;
    S_AXI_ARADDR  = '0;
    S_AXI_ARVALID = 1'b1;
    S_AXI_RREADY  = 1'b0;
    frame_start   = 1'b0;
    vblank        = 1'b0;
    repeat (3) tick();
    check("rst_ready", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
    check("rst_valid", {S_AXI_BVALID, S_AXI_RVALID}, 2'b00);
    check("rst_resp", {S_AXI_BRESP, S_AXI_RRESP}, 4'h0);
    check("rst_rdata", S_AXI_RDATA, 32'h0);
    check("rst_active", active_regs, 128'h0);
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    S_AXI_ARVALID = 1'b0;
    S_AXI_ARESET  = 1'b0;
    tick();

    // Program all four registers, read back; nothing committed yet.
    for (int i = 0; i < 4; i++) begin
      axi_write(5'(4 * i), wr_vals[i], 4'hF, 1'b0, resp);
      check("prog_bresp", resp, 2'b00);
    end
    check("prog_active_idle", active_regs, 128'h0);
    for (int i = 0; i < 4; i++) begin
      axi_read(5'(4 * i), rdata, resp);
      check("prog_rdata", rdata, wr_vals[i]);
      check("prog_rresp", resp, 2'b00);
    end

    // Byte strobes on REG1.
    axi_write(5'h04, 32'hFFFFFFFF, 4'hF, 1'b0, resp);
    axi_write(5'h04, 32'h12345678, 4'h5, 1'b0, resp);
    axi_read(5'h04, rdata, resp);
    check("strb_rdata", rdata, 32'hFF34FF78);

    // Pending and commit, with vblank high.
    vblank = 1'b1;
    tick();
    axi_write(5'h08, 32'hCAFEF00D, 4'hF, 1'b0, resp);
    axi_read(5'h10, rdata, resp);
    check("status_pending", rdata, 32'h00000003);
    frame_start = 1'b1;
    #1;
    check("commit_before_edge", active_regs, 128'h0);
    tick();
    frame_start = 1'b0;
    check("commit_reg2", active_regs[95:64], 32'hCAFEF00D);
    check("commit_all", active_regs,
          {32'hBEEF0011, 32'hCAFEF00D, 32'hFF34FF78, 32'h0101FFFF});
    axi_read(5'h10, rdata, resp);
    check("status_after_frame", rdata, 32'h00010002);

    // Write accepted on the commit edge: old value committed, pending stays.
    axi_write(5'h00, 32'h00000003, 4'hF, 1'b0, resp);
    axi_write(5'h00, 32'h00000005, 4'hF, 1'b1, resp);
    check("race_active_reg0", active_regs[31:0], 32'h00000003);
    axi_read(5'h10, rdata, resp);
    check("race_status", rdata, 32'h00020003);
    axi_read(5'h00, rdata, resp);
    check("race_reg0", rdata, 32'h00000005);

    // Read and write of REG3 accepted together: read sees the old value.
    S_AXI_AWADDR  = 5'h0C;
    S_AXI_WDATA   = 32'h11112222;
    S_AXI_WSTRB   = 4'hF;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WVALID  = 1'b1;
    S_AXI_ARADDR  = 5'h0C;
    S_AXI_ARVALID = 1'b1;
    #1;
    check("rw_same_ready", {S_AXI_AWREADY, S_AXI_ARREADY}, 2'b11);
    tick();
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    S_AXI_ARVALID = 1'b0;
    check("rw_same_valid", {S_AXI_BVALID, S_AXI_RVALID}, 2'b11);
    check("rw_same_rdata", S_AXI_RDATA, 32'hBEEF0011);
    S_AXI_BREADY = 1'b1;
    S_AXI_RREADY = 1'b1;
    tick();
    S_AXI_BREADY = 1'b0;
    S_AXI_RREADY = 1'b0;
    check("rw_same_drain", {S_AXI_BVALID, S_AXI_RVALID}, 2'b00);
    frame_pulse();
    check("commit_second", active_regs,
          {32'h11112222, 32'hCAFEF00D, 32'hFF34FF78, 32'h00000005});

    // Unmapped accesses and a discarded STATUS write.
    axi_write(5'h18, 32'h99999999, 4'hF, 1'b0, resp);
    check("unmapped_bresp", resp, 2'b10);
    axi_read(5'h14, rdata, resp);
    check("unmapped_rresp", resp, 2'b10);
    check("unmapped_rdata", rdata, 32'h0);
    axi_read(5'h1C, rdata, resp);
    check("unmapped_rresp_1c", {resp, rdata}, {2'b10, 32'h0});
    axi_read(5'h08, rdata, resp);
    check("unmapped_no_alias", rdata, 32'hCAFEF00D);
    axi_write(5'h10, 32'hFFFFFFFF, 4'hF, 1'b0, resp);
    check("status_wr_bresp", resp, 2'b00);
    axi_read(5'h10, rdata, resp);
    check("status_wr_discard", rdata, 32'h00030002);

    // Write backpressure: a second AW/W pair waits for B to drain.
    S_AXI_AWADDR  = 5'h04;
    S_AXI_WDATA   = 32'h00000042;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WVALID  = 1'b1;
    #1;
    check("bp_first_accept", S_AXI_AWREADY, 1'b1);
    tick();
    S_AXI_WDATA = 32'h00000077;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("bp_hold_w", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID}, 3'b001);
      tick();
    end
    S_AXI_BREADY = 1'b1;
    tick();
    S_AXI_BREADY = 1'b0;
    check("bp_second_accept", {S_AXI_BVALID, S_AXI_AWREADY}, 2'b01);
    tick();
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    check("bp_second_bvalid", S_AXI_BVALID, 1'b1);
    S_AXI_BREADY = 1'b1;
    tick();
    S_AXI_BREADY = 1'b0;

    // Read backpressure: RDATA holds while a new AR waits.
    S_AXI_ARADDR  = 5'h04;
    S_AXI_ARVALID = 1'b1;
    #1;
    check("rbp_first_accept", S_AXI_ARREADY, 1'b1);
    tick();
    S_AXI_ARADDR = 5'h0C;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("rbp_hold", {S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RDATA},
            {1'b0, 1'b1, 32'h00000077});
      tick();
    end
    S_AXI_RREADY = 1'b1;
    tick();
    S_AXI_RREADY = 1'b0;
    check("rbp_second_accept", {S_AXI_RVALID, S_AXI_ARREADY}, 2'b01);
    tick();
    S_AXI_ARVALID = 1'b0;
    check("rbp_second_rdata", {S_AXI_RVALID, S_AXI_RDATA}, {1'b1, 32'h11112222});
    S_AXI_RREADY = 1'b1;
    tick();
    S_AXI_RREADY = 1'b0;

    // Reset with both responses outstanding drops them and clears state.
    vblank        = 1'b0;
    S_AXI_AWADDR  = 5'h00;
    S_AXI_WDATA   = 32'h0000AAAA;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WVALID  = 1'b1;
    S_AXI_ARADDR  = 5'h04;
    S_AXI_ARVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    S_AXI_ARVALID = 1'b0;
    check("mid_rst_outstanding", {S_AXI_BVALID, S_AXI_RVALID}, 2'b11);
    S_AXI_ARESET = 1'b1;
    tick();
    S_AXI_ARESET = 1'b0;
    check("mid_rst_valid", {S_AXI_BVALID, S_AXI_RVALID}, 2'b00);
    check("mid_rst_outputs", {S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA}, 36'h0);
    check("mid_rst_active", active_regs, 128'h0);
    tick();
    axi_read(5'h00, rdata, resp);
    check("mid_rst_reg0", rdata, 32'h0);
    axi_read(5'h10, rdata, resp);
    check("mid_rst_status", rdata, 32'h0);

    // Frame counter wrap: 65535 frames, then one more.
    frame_start = 1'b1;
    repeat (65535) tick();
    frame_start = 1'b0;
    axi_read(5'h10, rdata, resp);
    check("frame_cnt_max", rdata, 32'hFFFF0000);
    frame_pulse();
    axi_read(5'h10, rdata, resp);
    check("frame_cnt_wrap", rdata, 32'h00000000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
